regbank_arbiter: RTL and testbench
==================================

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameters: ADRW, 1, register address width; DATW, 3, register data width; LOCK_MAX, 4, max cycles an internal lock may be held (1..15).
REQ-002 clk  in  1  single system clock (PLL output); all logic on rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 bus_do_write  in  1  one-cycle write pulse from external bus slave.
REQ-005 bus_do_read  in  1  one-cycle read pulse from external bus slave.
REQ-006 bus_adr  in  ADRW  bus address, stable while either pulse is high.
REQ-007 bus_wdata  in  DATW  bus write data.
REQ-008 bus_rdata  out  DATW  registered bus read data.
REQ-009 int_req  in  1  internal access request, held until granted.
REQ-010 int_we  in  1  internal access is a write.
REQ-011 int_lock  in  1  with a read: acquire lock; with a write: keep lock (0 releases it).
REQ-012 int_adr / int_wdata  in  ADRW / DATW  internal address / write data.
REQ-013 int_gnt  out  1  combinational, high in the cycle the internal access is performed.
REQ-014 int_rvalid / int_rdata  out  1 / DATW  internal read data, registered.
REQ-015 err_lock / err_ovf  out  1 / 1  sticky: lock timeout / post-buffer overwrite.
REQ-016 reg_out  out  (2**ADRW)*DATW  all bank registers, flattened, register 0 at LSBs.

Function
REQ-017 Single-port bank: at most one bank read or write per cycle.
REQ-018 States IDLE, LOCKED, DRAIN; IDLE on reset.
REQ-019 IDLE priority: bus_do_write > bus_do_read > int_req; int_gnt only in a cycle with no bus pulse.
REQ-020 Bus write in IDLE or DRAIN writes the bank in that cycle; new value visible on the next cycle.
REQ-021 Bus read: bus_rdata = addressed register, or the post-buffer data if pb_valid and addresses match, loaded 1 cycle after bus_do_read; bus_rdata holds otherwise.
REQ-022 bus_do_write and bus_do_read high together: write performed, read ignored, bus_rdata unchanged.
REQ-023 Internal read granted at T: int_rvalid = 1 and int_rdata valid at T+1 only.
REQ-024 Granted internal read with int_lock = 1: IDLE -> LOCKED, lock counter cleared to 0.
REQ-025 LOCKED: only int_req grants use the port (bus reads excepted, REQ-026); a granted write with int_lock = 0 releases the lock -> DRAIN if pb_valid, else IDLE.
REQ-026 LOCKED: bus_do_read uses the port that cycle (int_gnt = 0); bus_do_write goes to the one-entry post buffer (pb_adr, pb_data, pb_valid = 1), bank untouched.
REQ-027 Lock counter increments every LOCKED cycle; on reaching LOCK_MAX without release: forced release, err_lock set, -> DRAIN/IDLE as in REQ-025.
REQ-028 Bus write while pb_valid = 1: buffer overwritten with the new write, err_ovf set.
REQ-029 DRAIN, one cycle: post buffer written to the bank, pb_valid cleared, int_gnt = 0, -> IDLE; a bus write that cycle is performed after the drain in the same cycle (bus data wins on equal address), and a bus read is serviced with forwarding.
REQ-030 Internal write granted in IDLE with int_lock = 1: plain write, no lock taken.

Reset
REQ-031 nrst low: state IDLE, bank registers 0, bus_rdata 0, int_rdata 0, int_rvalid 0, pb_valid 0, lock counter 0, err_lock 0, err_ovf 0.
REQ-032 Reset mid-lock or with pb_valid set discards the buffered write; int_gnt is 0 while nrst is low.

Structure
REQ-033 Shared package holds the state encoding (IDLE/LOCKED/DRAIN) and the LOCK_MAX default.
REQ-034 One sub-module, regbank_store: 2**ADRW x DATW registers, one write port, combinational read, flattened output.

Verification
REQ-035 IDLE, bus_do_write adr 1 data 5 -> reg_out[5:3] = 5 the next cycle; bus_do_read adr 1 -> bus_rdata = 5 one cycle later.
REQ-036 bus_do_write and int_req (write) in the same cycle -> int_gnt = 0; int write granted in the following cycle.
REQ-037 Locked read adr 0, bus_do_write adr 0 data 3 mid-lock, int write 6 with unlock -> reg 0 = 6, then DRAIN -> reg 0 = 3.
REQ-038 Locked, bus_do_write adr 1 data 2, then bus_do_read adr 1 -> bus_rdata = 2 (forwarded) before the drain.
REQ-039 LOCK_MAX = 4, lock held with no release -> err_lock = 1 after 4 LOCKED cycles, state IDLE.
REQ-040 Two bus writes during one lock (data 1, then 7, adr 0) -> err_ovf = 1; after the drain reg 0 = 7.

Source files
------------

// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM state encoding and lock timing.
package regbank_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int LOCK_MAX_DEFAULT = 4;
    localparam int LOCK_CNT_W       = 4;

endpackage

// File: rtl/regbank_store.sv
// Register bank storage: combinational read and a write port that can also retire a
// drained post-buffer entry in the same cycle.
module regbank_store
    import regbank_arbiter_pkg::*;
#(
    parameter int ADRW = 1,
    parameter int DATW = 3
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         drain_we,
    input  logic [ADRW-1:0]              drain_adr,
    input  logic [DATW-1:0]              drain_data,
    input  logic                         we,
    input  logic [ADRW-1:0]              wadr,
    input  logic [DATW-1:0]              wdata,
    input  logic [ADRW-1:0]              radr,
    output logic [DATW-1:0]              rdata,
    output logic [(2**ADRW)*DATW-1:0]    regs_flat
);

    localparam int NREG = 2**ADRW;

    logic [DATW-1:0] mem [NREG];

    // The drain entry is retired first so a primary write to the same address wins.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we && wadr == ADRW'(i)) begin
                    mem[i] <= wdata;
                end else if (drain_we && drain_adr == ADRW'(i)) begin
                    mem[i] <= drain_data;
                end
            end
        end
    end

    assign rdata = mem[radr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*DATW +: DATW] = mem[g];
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates a single-port register bank between an external bus slave and an internal
// requester that can hold a timed lock; bus writes during a lock are parked in a post buffer.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | bus write > bus read > internal request share the port
// ST_LOCKED | internal side owns writes, bus writes go to the post buffer
// ST_DRAIN  | one cycle: post buffer retired to the bank, no internal grant
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int ADRW     = 1,
    parameter int DATW     = 3,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         bus_do_write,
    input  logic                         bus_do_read,
    input  logic [ADRW-1:0]              bus_adr,
    input  logic [DATW-1:0]              bus_wdata,
    output logic [DATW-1:0]              bus_rdata,
    input  logic                         int_req,
    input  logic                         int_we,
    input  logic                         int_lock,
    input  logic [ADRW-1:0]              int_adr,
    input  logic [DATW-1:0]              int_wdata,
    output logic                         int_gnt,
    output logic                         int_rvalid,
    output logic [DATW-1:0]              int_rdata,
    output logic                         err_lock,
    output logic                         err_ovf,
    output logic [(2**ADRW)*DATW-1:0]    reg_out
);

    state_t                state;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  pb_valid;
    logic [ADRW-1:0]       pb_adr;
    logic [DATW-1:0]       pb_data;

    logic                  gnt;
    logic                  st_we;
    logic                  drain_we;
    logic [ADRW-1:0]       st_wadr;
    logic [DATW-1:0]       st_wdata;
    logic [ADRW-1:0]       rd_adr;
    logic [DATW-1:0]       st_rdata;
    logic                  bus_rd_go;
    logic                  pb_hit;
    logic                  release_now;
    logic                  timeout;
    logic                  pb_valid_nx;

    always_comb begin
        gnt       = 1'b0;
        st_we     = 1'b0;
        drain_we  = 1'b0;
        bus_rd_go = bus_do_read && !bus_do_write;
        case (state)
            ST_IDLE: begin
                gnt   = nrst && int_req && !bus_do_write && !bus_do_read;
                st_we = bus_do_write || (gnt && int_we);
            end
            ST_LOCKED: begin
                gnt   = nrst && int_req && !bus_rd_go;
                st_we = gnt && int_we;
            end
            ST_DRAIN: begin
                drain_we = 1'b1;
                st_we    = bus_do_write;
            end
            default: begin
                gnt = 1'b0;
            end
        endcase
        st_wadr  = gnt ? int_adr : bus_adr;
        st_wdata = gnt ? int_wdata : bus_wdata;
        rd_adr   = gnt ? int_adr : bus_adr;
    end

    assign int_gnt     = gnt;
    assign pb_hit      = pb_valid && (pb_adr == bus_adr);
    assign release_now = (state == ST_LOCKED) && gnt && int_we && !int_lock;
    assign timeout     = (state == ST_LOCKED) && !release_now
                         && (lock_cnt == LOCK_CNT_W'(LOCK_MAX - 1));
    assign pb_valid_nx = pb_valid || ((state == ST_LOCKED) && bus_do_write);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            lock_cnt   <= '0;
            pb_valid   <= 1'b0;
            pb_adr     <= '0;
            pb_data    <= '0;
            bus_rdata  <= '0;
            int_rvalid <= 1'b0;
            int_rdata  <= '0;
            err_lock   <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            int_rvalid <= gnt && !int_we;
            if (gnt && !int_we) begin
                int_rdata <= st_rdata;
            end
            if (bus_rd_go) begin
                bus_rdata <= pb_hit ? pb_data : st_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (gnt && !int_we && int_lock) begin
                        state    <= ST_LOCKED;
                        lock_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (bus_do_write) begin
                        pb_valid <= 1'b1;
                        pb_adr   <= bus_adr;
                        pb_data  <= bus_wdata;
                        if (pb_valid) begin
                            err_ovf <= 1'b1;
                        end
                    end
                    if (release_now || timeout) begin
                        state <= pb_valid_nx ? ST_DRAIN : ST_IDLE;
                    end
                    if (timeout) begin
                        err_lock <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pb_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    regbank_store #(
        .ADRW (ADRW),
        .DATW (DATW)
    ) u_store (
        .clk        (clk),
        .nrst       (nrst),
        .drain_we   (drain_we),
        .drain_adr  (pb_adr),
        .drain_data (pb_data),
        .we         (st_we),
        .wadr       (st_wadr),
        .wdata      (st_wdata),
        .radr       (rd_adr),
        .rdata      (st_rdata),
        .regs_flat  (reg_out)
    );

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed scenarios plus a random run against a behavioural model.
module tb_regbank_arbiter;

    localparam int ADRW     = 1;
    localparam int DATW     = 3;
    localparam int LOCK_MAX = 4;
    localparam int NREG     = 2**ADRW;

    logic                      clk = 1'b0;
    logic                      nrst;
    logic                      bus_do_write;
    logic                      bus_do_read;
    logic [ADRW-1:0]           bus_adr;
    logic [DATW-1:0]           bus_wdata;
    logic [DATW-1:0]           bus_rdata;
    logic                      int_req;
    logic                      int_we;
    logic                      int_lock;
    logic [ADRW-1:0]           int_adr;
    logic [DATW-1:0]           int_wdata;
    logic                      int_gnt;
    logic                      int_rvalid;
    logic [DATW-1:0]           int_rdata;
    logic                      err_lock;
    logic                      err_ovf;
    logic [NREG*DATW-1:0]      reg_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: bank contents, lock ownership/age, pending post-buffer write.
    logic [DATW-1:0] m_bank [NREG];
    bit              m_locked;
    bit              m_drain_due;
    int              m_age;
    logic [ADRW-1:0] m_buf_adr [$];
    logic [DATW-1:0] m_buf_dat [$];
    bit              m_err_lock;
    bit              m_err_ovf;
    bit              m_rvalid;
    logic [DATW-1:0] m_bus_rdata;
    logic [DATW-1:0] m_int_rdata;

    always #5 clk = ~clk;

    regbank_arbiter #(
        .ADRW     (ADRW),
        .DATW     (DATW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .bus_do_write (bus_do_write),
        .bus_do_read  (bus_do_read),
        .bus_adr      (bus_adr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .int_req      (int_req),
        .int_we       (int_we),
        .int_lock     (int_lock),
        .int_adr      (int_adr),
        .int_wdata    (int_wdata),
        .int_gnt      (int_gnt),
        .int_rvalid   (int_rvalid),
        .int_rdata    (int_rdata),
        .err_lock     (err_lock),
        .err_ovf      (err_ovf),
        .reg_out      (reg_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic bw, input logic br, input logic [ADRW-1:0] badr,
                         input logic [DATW-1:0] bwd, input logic ireq, input logic iwe,
                         input logic ilock, input logic [ADRW-1:0] iadr,
                         input logic [DATW-1:0] iwd);
        bus_do_write = bw;
        bus_do_read  = br;
        bus_adr      = badr;
        bus_wdata    = bwd;
        int_req      = ireq;
        int_we       = iwe;
        int_lock     = ilock;
        int_adr      = iadr;
        int_wdata    = iwd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_bank[i] = '0;
        m_locked    = 1'b0;
        m_drain_due = 1'b0;
        m_age       = 0;
        m_buf_adr.delete();
        m_buf_dat.delete();
        m_err_lock  = 1'b0;
        m_err_ovf   = 1'b0;
        m_rvalid    = 1'b0;
        m_bus_rdata = '0;
        m_int_rdata = '0;
    endfunction

    function automatic bit model_gnt();
        bit bus_rd_only;
        bus_rd_only = bus_do_read && !bus_do_write;
        if (m_drain_due) return 1'b0;
        if (m_locked) return int_req && !bus_rd_only;
        return int_req && !bus_do_write && !bus_do_read;
    endfunction

    task automatic model_step(input bit g);
        bit bus_rd;
        bit rel;
        bit timed;
        bus_rd = bus_do_read && !bus_do_write;
        if (bus_rd) begin
            if (m_buf_adr.size() > 0 && m_buf_adr[0] == bus_adr) m_bus_rdata = m_buf_dat[0];
            else m_bus_rdata = m_bank[bus_adr];
        end
        m_rvalid = g && !int_we;
        if (m_rvalid) m_int_rdata = m_bank[int_adr];
        if (m_drain_due) begin
            m_bank[m_buf_adr[0]] = m_buf_dat[0];
            m_buf_adr.delete();
            m_buf_dat.delete();
            m_drain_due = 1'b0;
            if (bus_do_write) m_bank[bus_adr] = bus_wdata;
        end else if (m_locked) begin
            if (bus_do_write) begin
                if (m_buf_adr.size() > 0) begin
                    m_err_ovf = 1'b1;
                    m_buf_adr.delete();
                    m_buf_dat.delete();
                end
                m_buf_adr.push_back(bus_adr);
                m_buf_dat.push_back(bus_wdata);
            end
            if (g && int_we) m_bank[int_adr] = int_wdata;
            m_age++;
            rel   = g && int_we && !int_lock;
            timed = !rel && (m_age == LOCK_MAX);
            if (rel || timed) begin
                m_locked = 1'b0;
                if (timed) m_err_lock = 1'b1;
                m_drain_due = (m_buf_adr.size() > 0);
            end
        end else begin
            if (bus_do_write) m_bank[bus_adr] = bus_wdata;
            else if (g) begin
                if (int_we) m_bank[int_adr] = int_wdata;
                else if (int_lock) begin
                    m_locked = 1'b1;
                    m_age    = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", int_gnt); end
        checks++; if (bus_rdata !== 3'd0) begin errors++; $display("FAIL reset_bus_rdata got %0d want 0", bus_rdata); end
        checks++; if (int_rvalid !== 1'b0 || int_rdata !== 3'd0) begin errors++; $display("FAIL reset_int_rd got %b/%0d want 0/0", int_rvalid, int_rdata); end
        checks++; if (reg_out !== '0) begin errors++; $display("FAIL reset_reg_out got %h want 0", reg_out); end
        checks++; if (err_lock !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", err_lock, err_ovf); end
        tick();
        nrst = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_bus_write_read();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out[5:3] !== 3'd5) begin errors++; $display("FAIL bw_reg1 got %0d want 5", reg_out[5:3]); end
        drive(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (bus_rdata !== 3'd5) begin errors++; $display("FAIL br_reg1 got %0d want 5", bus_rdata); end
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (bus_rdata !== 3'd5 || reg_out !== {3'd5, 3'd2}) begin errors++; $display("FAIL wr_rd_same got rdata %0d regs %h want 5 2a", bus_rdata, reg_out); end
    endtask

    task automatic test_bus_vs_int();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL bw_blocks_gnt got %b want 0", int_gnt); end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
        #1;
        checks++; if (int_gnt !== 1'b1) begin errors++; $display("FAIL int_wr_next got %b want 1", int_gnt); end
        tick();
        checks++; if (reg_out !== {3'd6, 3'd1}) begin errors++; $display("FAIL int_wr_regs got %h want 31", reg_out); end
        drive(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL br_blocks_gnt got %b want 0", int_gnt); end
        tick();
        checks++; if (bus_rdata !== 3'd6 || int_rvalid !== 1'b0) begin errors++; $display("FAIL br_then got %0d/%b want 6/0", bus_rdata, int_rvalid); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        checks++; if (int_rvalid !== 1'b1 || int_rdata !== 3'd1) begin errors++; $display("FAIL int_rd got %b/%0d want 1/1", int_rvalid, int_rdata); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        checks++; if (int_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one got %b want 0", int_rvalid); end
        drive(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out[2:0] !== 3'd3) begin errors++; $display("FAIL wr_lock_nolock got %0d want 3", reg_out[2:0]); end
    endtask

    task automatic test_lock_post_drain();
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out[2:0] !== 3'd0) begin errors++; $display("FAIL lock_posted got %0d want 0", reg_out[2:0]); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6);
        #1;
        checks++; if (int_gnt !== 1'b1) begin errors++; $display("FAIL lock_wr_gnt got %b want 1", int_gnt); end
        tick();
        checks++; if (reg_out[2:0] !== 3'd6) begin errors++; $display("FAIL unlock_wr got %0d want 6", reg_out[2:0]); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL drain_gnt got %b want 0", int_gnt); end
        tick();
        checks++; if (reg_out[2:0] !== 3'd3) begin errors++; $display("FAIL drained got %0d want 3", reg_out[2:0]); end
        tick();
        checks++; if (reg_out[5:3] !== 3'd1) begin errors++; $display("FAIL post_drain_wr got %0d want 1", reg_out[5:3]); end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL lock_br_gnt got %b want 0", int_gnt); end
        tick();
        checks++; if (bus_rdata !== 3'd2 || reg_out[5:3] !== 3'd0) begin errors++; $display("FAIL fwd got %0d reg1 %0d want 2 0", bus_rdata, reg_out[5:3]); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        tick();
        drive(1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out !== {3'd7, 3'd4}) begin errors++; $display("FAIL drain_bus_wins got %h want 3c", reg_out); end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        idle();
        for (int k = 1; k <= LOCK_MAX; k++) begin
            tick();
            checks++;
            if (err_lock !== (k == LOCK_MAX)) begin
                errors++;
                $display("FAIL lock_timeout_cyc%0d got %b want %b", k, err_lock, (k == LOCK_MAX));
            end
        end
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out[5:3] !== 3'd5) begin errors++; $display("FAIL timeout_idle got %0d want 5", reg_out[5:3]); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1, '0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first got %b want 0", err_ovf); end
        drive(1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_second got %b want 1", err_ovf); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        tick();
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++; if (reg_out !== {3'd5, 3'd7} || err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_drain got %h/%b want 2f/1", reg_out, err_ovf); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        nrst = 1'b0;
        #1;
        checks++; if (int_gnt !== 1'b0) begin errors++; $display("FAIL rst_lock_gnt got %b want 0", int_gnt); end
        tick();
        nrst = 1'b1;
        idle();
        for (int k = 0; k < 3; k++) tick();
        checks++; if (reg_out !== '0) begin errors++; $display("FAIL rst_discard got %h want 0", reg_out); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        #1;
        checks++; if (int_gnt !== 1'b1) begin errors++; $display("FAIL rst_idle_gnt got %b want 1", int_gnt); end
        tick();
        idle();
    endtask

    task automatic test_random();
        bit              pend;
        bit              exp_g;
        logic            p_we;
        logic            p_lock;
        logic [ADRW-1:0] p_adr;
        logic [DATW-1:0] p_wd;
        logic [NREG*DATW-1:0] exp_regs;
        pend = 1'b0;
        p_we = 1'b0; p_lock = 1'b0; p_adr = '0; p_wd = '0;
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            if (!pend && $urandom_range(0, 9) < 5) begin
                pend   = 1'b1;
                p_we   = 1'($urandom_range(0, 1));
                p_lock = 1'($urandom_range(0, 2) != 0);
                p_adr  = ADRW'($urandom_range(0, NREG-1));
                p_wd   = DATW'($urandom_range(0, 7));
            end
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                  ADRW'($urandom_range(0, NREG-1)), DATW'($urandom_range(0, 7)),
                  pend, p_we, p_lock, p_adr, p_wd);
            #1;
            exp_g = model_gnt();
            checks++; if (int_gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt c%0d got %b want %b", c, int_gnt, exp_g); end
            model_step(exp_g);
            if (exp_g) pend = 1'b0;
            tick();
            for (int i = 0; i < NREG; i++) exp_regs[i*DATW +: DATW] = m_bank[i];
            checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL rnd_regs c%0d got %h want %h", c, reg_out, exp_regs); end
            checks++; if (bus_rdata !== m_bus_rdata) begin errors++; $display("FAIL rnd_bus_rdata c%0d got %0d want %0d", c, bus_rdata, m_bus_rdata); end
            checks++; if (int_rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d got %b want %b", c, int_rvalid, m_rvalid); end
            if (m_rvalid) begin
                checks++; if (int_rdata !== m_int_rdata) begin errors++; $display("FAIL rnd_int_rdata c%0d got %0d want %0d", c, int_rdata, m_int_rdata); end
            end
            checks++; if (err_lock !== m_err_lock || err_ovf !== m_err_ovf) begin errors++; $display("FAIL rnd_err c%0d got %b%b want %b%b", c, err_lock, err_ovf, m_err_lock, m_err_ovf); end
        end
        idle();
    endtask

    initial begin
        nrst = 1'b1;
        idle();
        #1;
        test_reset();
        test_bus_write_read();
        test_bus_vs_int();
        test_lock_post_drain();
        test_forwarding();
        test_lock_timeout();
        test_overflow();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
